uart_cmd_wrapper: RTL
=====================

# uart_cmd_wrapper

Robot-side endpoint of the remote command link. It receives two UART bytes from the remote controller, high byte first, and presents them as one 16-bit `cmd` with a sticky `cmd_rdy` flag to the command processor. It also serializes the 8-bit response/acknowledge byte (e.g. positive ack 0xA5) back to the remote. It sits between the `RX`/`TX` pins and the command-processing state machine inside KnightsTour.

## Interface
- `BAUD_DIV`, default 2604: clocks per bit (50 MHz / 19200 baud).
- `GAP_BITS`, default 32: maximum bit-times allowed between the end of the high byte and the start of the low byte.
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `RX`  in  1  serial in, idle high, asynchronous to `clk`.
- `TX`  out  1  serial out, idle high.
- `cmd`  out  16  last assembled command, `{high_byte, low_byte}`.
- `cmd_rdy`  out  1  sticky; a complete command is valid.
- `clr_cmd_rdy`  in  1  pulse from the consumer; clears `cmd_rdy`.
- `resp`  in  8  response byte to send.
- `trmt`  in  1  pulse; starts transmission of `resp`.
- `tx_done`  out  1  sticky; the last response frame is fully sent.

## Operation
- Frame format: 8N1, LSB first. Start bit 0, 8 data bits, stop bit 1.
- RX input:
  - Double-flop synchronizer, preset to 1 on reset.
  - A falling edge in idle starts a frame.
  - Wait `BAUD_DIV/2` clocks, then re-check the start bit. If it is high, treat it as a glitch and return to idle.
  - Then sample every `BAUD_DIV` clocks: 8 data bits, then the stop bit.
  - Stop bit = 1: internal `rx_rdy` pulses for 1 clk with the byte. Stop bit = 0: framing error, byte dropped, no pulse.
- Assembly FSM, states `WAIT_HI` and `WAIT_LO`. Reset state is `WAIT_HI`.
  - `WAIT_HI` + `rx_rdy`: latch the high byte, clear `cmd_rdy`, load the gap counter, go to `WAIT_LO`.
  - `WAIT_LO` + `rx_rdy`: `cmd <= {hi, byte}`, set `cmd_rdy`, go to `WAIT_HI`.
  - `WAIT_LO` with no start bit within `GAP_BITS*BAUD_DIV` clocks: discard the high byte, go to `WAIT_HI`. `cmd` and `cmd_rdy` are unchanged.
  - The gap counter freezes while an RX frame is in progress.
- `cmd_rdy` rules:
  - Cleared by `clr_cmd_rdy` or by acceptance of a new high byte.
  - If the set and `clr_cmd_rdy` occur in the same cycle, set wins.
- `cmd` holds its value until the next complete command.
- TX:
  - On `trmt` while idle: load the 10-bit shift register `{1, resp, 0}`, clear `tx_done`, shift out one bit per `BAUD_DIV` clocks.
  - `tx_done` is set on the clock the stop-bit period ends; `TX` then stays 1.
  - `trmt` while busy is ignored. `resp` is sampled only on an accepted `trmt`.
- RX and TX are fully independent, so full duplex works.

## Timing
- Reset values: `TX`=1, `cmd`=16'h0000, `cmd_rdy`=0, `tx_done`=0, FSM=`WAIT_HI`, both baud counters 0.
- RX latency: `rx_rdy` fires at mid-stop-bit, about 9.5 bit-times + 2 sync clocks after the start edge. `cmd_rdy` is high on the next clk after the low byte's `rx_rdy`.
- TX:
  - The start bit appears on `TX` the clock after `trmt`.
  - A frame lasts exactly `10*BAUD_DIV` clocks.
  - `tx_done` rises `10*BAUD_DIV`+1 clocks after `trmt`.
- Back-to-back RX: a new start edge is accepted immediately after the stop sample, so there is no dead time.
- Reset mid-frame: both engines abort. `TX` is forced to 1 asynchronously and any partial byte or half-assembled command is discarded.

## Structure
- Shared package, reused by other link blocks:
  - `BAUD_DIV_19200` constant.
  - Response constants `RESP_POS_ACK=8'hA5`, `RESP_NACK=8'h5A`.
  - The assembly FSM state enum.
- One sub-module, `uart_xcvr`: baud counters and shift registers for both RX and TX, with the `rx_rdy`/`rx_data` and `trmt`/`tx_done` handshakes.
- The wrapper holds the assembly FSM, the gap timer and the `cmd`/`cmd_rdy` registers.

## Test plan
- Send bytes 0x4B then 0xF1 via a bench UART at `BAUD_DIV`: `cmd`=16'h4BF1 and `cmd_rdy`=1 one clk after the second stop sample; `clr_cmd_rdy` then drops it next clk with `cmd` held.
- Pulse `trmt` with `resp`=0xA5: `TX` shows 0,1,0,1,0,0,1,0,1,1 at mid-bit; `tx_done` rises at `10*BAUD_DIV`+1; a second `trmt` mid-frame with 0x00 is ignored.
- Send 0x47, idle `GAP_BITS`+1 bit-times, then 0x11, 0x22: `cmd`=16'h1122, and 0x47 never appears.
- Send a frame with stop bit 0 as the high byte, then 0x33, 0x44: `cmd`=16'h3344.
- Complete a command with `clr_cmd_rdy` asserted in the same clk: `cmd_rdy`=1.
- Assert `rst` mid-way through a low byte and mid-way through a TX frame: all outputs return to reset values immediately; next command 0x4BF1 is assembled correctly.

Source files
------------

// File: rtl/uart_cmd_wrapper_pkg.sv
// uart_cmd_wrapper_pkg: link constants and the command-assembly state type,
// shared by the remote-link blocks.
package uart_cmd_wrapper_pkg;
    localparam int BAUD_DIV_19200 = 2604;
    localparam logic [7:0] RESP_POS_ACK = 8'hA5;
    localparam logic [7:0] RESP_NACK = 8'h5A;
    typedef enum logic {WAIT_HI, WAIT_LO} asm_state_e;
endpackage

// File: rtl/uart_xcvr.sv
// uart_xcvr: 8N1 receiver and transmitter with independent baud counters.
module uart_xcvr import uart_cmd_wrapper_pkg::*; #(
    parameter int BAUD_DIV = BAUD_DIV_19200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_i,
    output logic       tx_o,
    output logic       rx_rdy_o,
    output logic [7:0] rx_data_o,
    output logic       rx_busy_o,
    input  logic       trmt_i,
    input  logic [7:0] tx_data_i,
    output logic       tx_done_o
);
    localparam int CW = $clog2(BAUD_DIV + 1);
    localparam logic [CW-1:0] FULL = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] HALF = CW'(BAUD_DIV / 2 - 1);

    logic [2:0]    sync_q;
    logic          rx_busy_q, rx_rdy_q;
    logic [CW-1:0] rx_cnt_q;
    logic [3:0]    rx_bit_q;
    logic [7:0]    rx_sh_q;
    logic          tx_busy_q, tx_done_q;
    logic [CW-1:0] tx_cnt_q;
    logic [3:0]    tx_bit_q;
    logic [9:0]    tx_sh_q;
    logic          rx_s, rx_fall;

    // sync_q[1] is the synchronized line, sync_q[2] its previous value
    assign rx_s      = sync_q[1];
    assign rx_fall   = sync_q[2] & ~sync_q[1];
    assign rx_rdy_o  = rx_rdy_q;
    assign rx_data_o = rx_sh_q;
    assign rx_busy_o = rx_busy_q;
    assign tx_o      = tx_sh_q[0];
    assign tx_done_o = tx_done_q;

    // rx_bit_q: 0 = start-bit recheck, 1..8 = data, 9 = stop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q    <= '1;
            rx_busy_q <= 1'b0;
            rx_rdy_q  <= 1'b0;
            rx_cnt_q  <= '0;
            rx_bit_q  <= '0;
            rx_sh_q   <= '0;
        end else begin
            sync_q   <= {sync_q[1:0], rx_i};
            rx_rdy_q <= 1'b0;
            if (!rx_busy_q) begin
                if (rx_fall) begin
                    rx_busy_q <= 1'b1;
                    rx_cnt_q  <= HALF;
                    rx_bit_q  <= '0;
                end
            end else if (rx_cnt_q != '0) begin
                rx_cnt_q <= rx_cnt_q - CW'(1);
            end else begin
                rx_cnt_q <= FULL;
                rx_bit_q <= rx_bit_q + 4'd1;
                if (rx_bit_q == 4'd0) begin
                    rx_busy_q <= ~rx_s;
                end else if (rx_bit_q == 4'd9) begin
                    rx_busy_q <= 1'b0;
                    rx_rdy_q  <= rx_s;
                end else begin
                    rx_sh_q <= {rx_s, rx_sh_q[7:1]};
                end
            end
        end
    end

    // shifting in ones keeps the line idle-high once the stop bit leaves
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_busy_q <= 1'b0;
            tx_done_q <= 1'b0;
            tx_cnt_q  <= '0;
            tx_bit_q  <= '0;
            tx_sh_q   <= '1;
        end else if (!tx_busy_q) begin
            if (trmt_i) begin
                tx_busy_q <= 1'b1;
                tx_done_q <= 1'b0;
                tx_cnt_q  <= FULL;
                tx_bit_q  <= '0;
                tx_sh_q   <= {1'b1, tx_data_i, 1'b0};
            end
        end else if (tx_cnt_q != '0) begin
            tx_cnt_q <= tx_cnt_q - CW'(1);
        end else begin
            tx_cnt_q <= FULL;
            tx_bit_q <= tx_bit_q + 4'd1;
            tx_sh_q  <= {1'b1, tx_sh_q[9:1]};
            if (tx_bit_q == 4'd9) begin
                tx_busy_q <= 1'b0;
                tx_done_q <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/uart_cmd_wrapper.sv
// uart_cmd_wrapper: assembles two received bytes into a 16-bit command and
// sends the response byte back over the same link.
module uart_cmd_wrapper import uart_cmd_wrapper_pkg::*; #(
    parameter int BAUD_DIV = BAUD_DIV_19200,
    parameter int GAP_BITS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RX,
    output logic        TX,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic [7:0]  resp,
    input  logic        trmt,
    output logic        tx_done
);
    localparam int GW = $clog2(GAP_BITS * BAUD_DIV + 1);
    localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_BITS * BAUD_DIV - 1);

    asm_state_e    state_q, state_d;
    logic [7:0]    hi_q, hi_d;
    logic [15:0]   cmd_q, cmd_d;
    logic          rdy_q, rdy_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          rx_rdy, rx_busy;
    logic [7:0]    rx_data;

    uart_xcvr #(.BAUD_DIV(BAUD_DIV)) u_xcvr (
        .clk      (clk),
        .rst      (rst),
        .rx_i     (RX),
        .tx_o     (TX),
        .rx_rdy_o (rx_rdy),
        .rx_data_o(rx_data),
        .rx_busy_o(rx_busy),
        .trmt_i   (trmt),
        .tx_data_i(resp),
        .tx_done_o(tx_done)
    );

    assign cmd     = cmd_q;
    assign cmd_rdy = rdy_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= WAIT_HI;
            hi_q    <= '0;
            cmd_q   <= '0;
            rdy_q   <= 1'b0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            cmd_q   <= cmd_d;
            rdy_q   <= rdy_d;
            gap_q   <= gap_d;
        end
    end

    // the gap timer only runs while the line is idle between bytes
    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        cmd_d   = cmd_q;
        rdy_d   = rdy_q & ~clr_cmd_rdy;
        gap_d   = gap_q;
        case (state_q)
            WAIT_HI: if (rx_rdy) begin
                hi_d    = rx_data;
                rdy_d   = 1'b0;
                gap_d   = GAP_LOAD;
                state_d = WAIT_LO;
            end
            WAIT_LO: if (rx_rdy) begin
                cmd_d   = {hi_q, rx_data};
                rdy_d   = 1'b1;
                state_d = WAIT_HI;
            end else if (!rx_busy) begin
                state_d = (gap_q == '0) ? WAIT_HI : WAIT_LO;
                gap_d   = gap_q - GW'(1);
            end
            default: state_d = WAIT_HI;
        endcase
    end
endmodule
